// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//
// N-to-1 APB arbiter. One pending upstream requester is chosen, its request
// is captured into registers and replayed downstream as a clean SETUP/ACCESS
// pair. All other requesters see pready low until their own turn. The
// granted requester's hart ID travels downstream with the transfer.
//
// Build option:
//   APB_ARBITER_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin starting at rr_ptr
//
// Parameters:
//   N_MASTERS  number of upstream requesters (2..8)
//   W_ADDR     APB address width
//   W_DATA     APB data width, also the hart-ID width
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   apbs_*  (packed, requester i at [i*W +: W])
//     paddr/psel/penable/pwrite/pwdata/phartid   upstream request inputs
//     pready/prdata/pslverr                      upstream response outputs
//   apbm_*
//     paddr/psel/penable/pwrite/pwdata/phartid   downstream request outputs
//     pready/prdata/pslverr                      downstream response inputs
// ---------------------------------------------------------------------------
module apb_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int W_ADDR    = 16,
    parameter int W_DATA    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS*W_ADDR-1:0]   apbs_paddr,
    input  logic [N_MASTERS-1:0]          apbs_psel,
    input  logic [N_MASTERS-1:0]          apbs_penable,
    input  logic [N_MASTERS-1:0]          apbs_pwrite,
    input  logic [N_MASTERS*W_DATA-1:0]   apbs_pwdata,
    input  logic [N_MASTERS*W_DATA-1:0]   apbs_phartid,
    output logic [N_MASTERS-1:0]          apbs_pready,
    output logic [N_MASTERS*W_DATA-1:0]   apbs_prdata,
    output logic [N_MASTERS-1:0]          apbs_pslverr,
    output logic [W_ADDR-1:0]             apbm_paddr,
    output logic                          apbm_psel,
    output logic                          apbm_penable,
    output logic                          apbm_pwrite,
    output logic [W_DATA-1:0]             apbm_pwdata,
    output logic [W_DATA-1:0]             apbm_phartid,
    input  logic                          apbm_pready,
    input  logic [W_DATA-1:0]             apbm_prdata,
    input  logic                          apbm_pslverr
);

    localparam int W_IDX = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_capture;
    logic               w_done;
    logic               w_found;
    logic [W_IDX-1:0]   w_winner;
    logic [W_IDX-1:0]   w_cand;

    logic [W_IDX-1:0]   r_grant;
    logic [W_ADDR-1:0]  r_paddr;
    logic               r_pwrite;
    logic [W_DATA-1:0]  r_pwdata;
    logic [W_DATA-1:0]  r_phartid;

    // Upstream penable carries no information the arbiter needs: a request
    // is recognised on psel alone and replayed with our own SETUP/ACCESS.
    logic               w_unused_penable;
    assign w_unused_penable = ^apbs_penable;

    // Completion cycle: downstream ACCESS accepted this cycle.
    assign w_done = (r_state == ST_ACCESS) && apbm_pready;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef APB_ARBITER_FIXED_PRIO_EN
    // Scan from the top down so the lowest pending index is written last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            w_cand = W_IDX'(k);
            if (apbs_psel[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end
`else
    logic [W_IDX-1:0]   r_rr_ptr;

    // Search upward from rr_ptr with wrap-around; first pending one wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            w_cand = W_IDX'((int'(r_rr_ptr) + k) % N_MASTERS);
            if (!w_found && apbs_psel[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // The pointer moves past the requester just served, so it drops to the
    // back of the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_done) begin
            r_rr_ptr <= (int'(r_grant) == N_MASTERS - 1) ? '0 : r_grant + W_IDX'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_SETUP;
                    w_capture    = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apbm_pready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture. Downstream fields come only from these registers,
    // so upstream changes after arbitration cannot disturb the transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_phartid <= '0;
        end else if (w_capture) begin
            r_grant   <= w_winner;
            r_paddr   <= apbs_paddr[w_winner*W_ADDR +: W_ADDR];
            r_pwrite  <= apbs_pwrite[w_winner];
            r_pwdata  <= apbs_pwdata[w_winner*W_DATA +: W_DATA];
            r_phartid <= apbs_phartid[w_winner*W_DATA +: W_DATA];
        end
    end

    assign apbm_psel    = (r_state != ST_IDLE);
    assign apbm_penable = (r_state == ST_ACCESS);
    assign apbm_paddr   = r_paddr;
    assign apbm_pwrite  = r_pwrite;
    assign apbm_pwdata  = r_pwdata;
    assign apbm_phartid = r_phartid;

    // ------------------------------------------------------------------
    // Upstream responses: only the granted requester, only in the
    // completion cycle. Not masked by the requester's current psel, so a
    // requester that dropped psel mid-transfer still sees its pulse.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_resp
            logic w_hit;
            assign w_hit = w_done && (r_grant == W_IDX'(gi));
            assign apbs_pready[gi]                   = w_hit;
            assign apbs_pslverr[gi]                  = w_hit & apbm_pslverr;
            assign apbs_prdata[gi*W_DATA +: W_DATA]  = w_hit ? apbm_prdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_apb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_arbiter
//
// Directed scenarios with literal expectations followed by a long random
// phase. A transaction-level model (busy flag, cycle count since grant,
// rotating pointer) predicts every DUT output on each falling edge.
// ---------------------------------------------------------------------------
module tb_apb_arbiter;

    localparam int N  = 2;
    localparam int WA = 16;
    localparam int WD = 32;

`ifdef APB_ARBITER_FIXED_PRIO_EN
    localparam int SECOND_FIRST = 0;
`else
    localparam int SECOND_FIRST = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*WA-1:0]   s_paddr;
    logic [N-1:0]      s_psel;
    logic [N-1:0]      s_penable;
    logic [N-1:0]      s_pwrite;
    logic [N*WD-1:0]   s_pwdata;
    logic [N*WD-1:0]   s_phartid;
    logic [N-1:0]      s_pready;
    logic [N*WD-1:0]   s_prdata;
    logic [N-1:0]      s_pslverr;
    logic [WA-1:0]     m_paddr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [WD-1:0]     m_pwdata;
    logic [WD-1:0]     m_phartid;
    logic              m_pready;
    logic [WD-1:0]     m_prdata;
    logic              m_pslverr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_arbiter #(.N_MASTERS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_paddr   (s_paddr),
        .apbs_psel    (s_psel),
        .apbs_penable (s_penable),
        .apbs_pwrite  (s_pwrite),
        .apbs_pwdata  (s_pwdata),
        .apbs_phartid (s_phartid),
        .apbs_pready  (s_pready),
        .apbs_prdata  (s_prdata),
        .apbs_pslverr (s_pslverr),
        .apbm_paddr   (m_paddr),
        .apbm_psel    (m_psel),
        .apbm_penable (m_penable),
        .apbm_pwrite  (m_pwrite),
        .apbm_pwdata  (m_pwdata),
        .apbm_phartid (m_phartid),
        .apbm_pready  (m_pready),
        .apbm_prdata  (m_prdata),
        .apbm_pslverr (m_pslverr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit              mdl_busy;
    int              mdl_cnt;      // 1 = setup cycle, 2+ = access cycles
    int              mdl_grant;
    int              mdl_rr;
    logic [WA-1:0]   mdl_addr;
    logic            mdl_write;
    logic [WD-1:0]   mdl_wdata;
    logic [WD-1:0]   mdl_hart;
    bit              mdl_done;
    bit              mdl_found;
    int              mdl_idx;
    logic [N-1:0]    e_pready;
    logic [N-1:0]    e_err;
    logic [N*WD-1:0] e_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_busy  = 1'b0;
            mdl_cnt   = 0;
            mdl_grant = 0;
            mdl_rr    = 0;
        end
        mdl_done = mdl_busy && (mdl_cnt >= 2) && (m_pready === 1'b1);
        e_pready = '0;
        e_err    = '0;
        e_rdata  = '0;
        if (mdl_done) begin
            e_pready[mdl_grant]             = 1'b1;
            e_err[mdl_grant]                = m_pslverr;
            e_rdata[mdl_grant*WD +: WD]     = m_prdata;
        end
        chk("m_psel",    m_psel,    mdl_busy);
        chk("m_penable", m_penable, mdl_busy && (mdl_cnt >= 2));
        chk("s_pready",  s_pready,  e_pready);
        chk("s_pslverr", s_pslverr, e_err);
        chk("s_prdata",  s_prdata,  e_rdata);
        if (mdl_busy) begin
            chk("m_paddr",   m_paddr,   mdl_addr);
            chk("m_pwrite",  m_pwrite,  mdl_write);
            chk("m_pwdata",  m_pwdata,  mdl_wdata);
            chk("m_phartid", m_phartid, mdl_hart);
        end else if (!rst_n) begin
            chk("rst_m_paddr",   m_paddr,   0);
            chk("rst_m_pwrite",  m_pwrite,  0);
            chk("rst_m_pwdata",  m_pwdata,  0);
            chk("rst_m_phartid", m_phartid, 0);
        end
        if (rst_n) begin
            if (!mdl_busy) begin
                mdl_found = 1'b0;
                for (int k = 0; k < N; k++) begin
`ifdef APB_ARBITER_FIXED_PRIO_EN
                    mdl_idx = k;
`else
                    mdl_idx = (mdl_rr + k) % N;
`endif
                    if (!mdl_found && s_psel[mdl_idx]) begin
                        mdl_found = 1'b1;
                        mdl_grant = mdl_idx;
                    end
                end
                if (mdl_found) begin
                    mdl_busy  = 1'b1;
                    mdl_cnt   = 1;
                    mdl_addr  = s_paddr[mdl_grant*WA +: WA];
                    mdl_write = s_pwrite[mdl_grant];
                    mdl_wdata = s_pwdata[mdl_grant*WD +: WD];
                    mdl_hart  = s_phartid[mdl_grant*WD +: WD];
                end
            end else if (mdl_cnt == 1) begin
                mdl_cnt = 2;
            end else if (mdl_done) begin
                $display("xfer req=%0d wr=%0d addr=%h wdata=%h hart=%h rdata=%h err=%0d",
                         mdl_grant, mdl_write, mdl_addr, mdl_wdata, mdl_hart, m_prdata, m_pslverr);
                mdl_busy = 1'b0;
                mdl_rr   = (mdl_grant + 1) % N;
            end else begin
                mdl_cnt = mdl_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit sel, input bit wr,
                           input logic [WA-1:0] a, input logic [WD-1:0] d,
                           input logic [WD-1:0] h);
        s_psel[i]            = sel;
        s_penable[i]         = 1'b0;
        s_pwrite[i]          = wr;
        s_paddr[i*WA +: WA]  = a;
        s_pwdata[i*WD +: WD] = d;
        s_phartid[i*WD +: WD] = h;
    endtask

    // Both requesters ask in the same cycle; 'first' must be served first.
    task automatic contend(input int first);
        int second;
        logic [N-1:0] one_hot;
        second = 1 - first;
        tick();
        set_req(0, 1'b1, 1'b1, 16'h0100, 32'hA0A0A0A0, 32'd0);
        set_req(1, 1'b1, 1'b0, 16'h0200, 32'hB0B0B0B0, 32'd1);
        m_pready = 1'b1;
        at_neg();
        chk("cont_idle_psel", m_psel, 0);
        tick(); at_neg();
        chk("cont_hart_first", m_phartid, first);
        tick(); at_neg();
        one_hot = '0; one_hot[first] = 1'b1;
        chk("cont_pready_first", s_pready, one_hot);
        tick();
        s_psel[first] = 1'b0;
        at_neg();
        chk("cont_gap_psel", m_psel, 0);
        tick(); at_neg();
        chk("cont_hart_second", m_phartid, second);
        tick(); at_neg();
        one_hot = '0; one_hot[second] = 1'b1;
        chk("cont_pready_second", s_pready, one_hot);
        tick();
        s_psel[second] = 1'b0;
    endtask

    int g1;

    initial begin
        rst_n     = 1'b0;
        s_paddr   = '0;
        s_psel    = '0;
        s_penable = '0;
        s_pwrite  = '0;
        s_pwdata  = '0;
        s_phartid = '0;
        m_pready  = 1'b0;
        m_prdata  = '0;
        m_pslverr = 1'b0;

        // Reset state
        repeat (3) tick();
        at_neg();
        chk("rst_psel", m_psel, 0);
        chk("rst_s_pready", s_pready, 0);
        chk("rst_m_paddr_lit", m_paddr, 0);
        tick();
        rst_n = 1'b1;

        // Single write, zero wait states
        tick();
        set_req(0, 1'b1, 1'b1, 16'h2004, 32'hDEADBEEF, 32'd0);
        m_pready = 1'b1;
        at_neg();
        chk("wr_idle_psel", m_psel, 0);
        tick(); at_neg();
        chk("wr_setup_sel_en", {m_psel, m_penable}, 2'b10);
        chk("wr_addr", m_paddr, 16'h2004);
        chk("wr_data", m_pwdata, 32'hDEADBEEF);
        chk("wr_pwrite", m_pwrite, 1);
        tick(); at_neg();
        chk("wr_access_sel_en", {m_psel, m_penable}, 2'b11);
        chk("wr_pready", s_pready, 2'b01);
        tick();
        s_psel[0] = 1'b0;
        at_neg();
        chk("wr_after_pready", s_pready, 0);

        // Read with two wait states
        tick();
        set_req(1, 1'b1, 1'b0, 16'h4000, 32'h0, 32'd1);
        m_pready = 1'b0;
        at_neg();
        tick(); at_neg();
        chk("rd_setup_addr", m_paddr, 16'h4000);
        tick(); at_neg();
        chk("rd_wait1", s_pready, 0);
        tick(); at_neg();
        chk("rd_wait2", s_pready, 0);
        tick();
        m_pready = 1'b1;
        m_prdata = 32'h12345678;
        at_neg();
        chk("rd_pready", s_pready, 2'b10);
        chk("rd_prdata1", s_prdata[63:32], 32'h12345678);
        chk("rd_prdata0", s_prdata[31:0], 32'h0);
        tick();
        s_psel[1] = 1'b0;

        // Contention with rotation pointer at 0
        contend(0);

        // Error response from requester 0
        tick();
        set_req(0, 1'b1, 1'b0, 16'h0010, 32'h0, 32'd0);
        m_pready  = 1'b1;
        m_pslverr = 1'b1;
        at_neg();
        chk("err_idle", s_pslverr, 0);
        tick(); at_neg();
        chk("err_setup", s_pslverr, 0);
        tick(); at_neg();
        chk("err_done", s_pslverr, 2'b01);
        tick();
        s_psel[0] = 1'b0;
        m_pslverr = 1'b0;

        // Contention again: round-robin now favours requester 1
        contend(SECOND_FIRST);

        // Reset during ACCESS
        tick();
        set_req(0, 1'b1, 1'b1, 16'h3000, 32'hCAFEF00D, 32'd0);
        m_pready = 1'b0;
        at_neg();
        tick(); at_neg();
        tick();
        m_pready = 1'b1;
        #1;
        chk("rst_mid_before", s_pready, 2'b01);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_psel", m_psel, 0);
        chk("rst_mid_penable", m_penable, 0);
        chk("rst_mid_pready", s_pready, 0);
        tick();
        rst_n = 1'b1;
        at_neg();
        tick(); at_neg();
        tick(); at_neg();
        chk("rst_after_pready", s_pready, 2'b01);
        tick();
        s_psel[0] = 1'b0;

        // Both requesters continuously pending
        tick();
        set_req(0, 1'b1, 1'b1, 16'h0500, 32'h11111111, 32'd0);
        set_req(1, 1'b1, 1'b1, 16'h0600, 32'h22222222, 32'd1);
        m_pready = 1'b1;
        g1 = 0;
        repeat (30) begin
            at_neg();
            if (m_psel && !m_penable && m_phartid == 32'd1) g1++;
        end
`ifdef APB_ARBITER_FIXED_PRIO_EN
        chk("starve_req1_grants", g1, 0);
`else
        chk("rr_req1_grants", g1 >= 4, 1);
`endif
        tick();
        s_psel = '0;

        // Random phase
        repeat (3000) begin
            tick();
            rst_n     = ($urandom_range(0, 299) != 0);
            s_psel    = N'($urandom);
            s_penable = N'($urandom);
            s_pwrite  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                s_paddr[i*WA +: WA]   = WA'($urandom);
                s_pwdata[i*WD +: WD]  = $urandom;
                s_phartid[i*WD +: WD] = $urandom;
            end
            m_pready  = ($urandom_range(0, 2) != 0);
            m_prdata  = $urandom;
            m_pslverr = ($urandom_range(0, 3) == 0);
        end

        tick();
        rst_n  = 1'b1;
        s_psel = '0;
        at_neg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- N-to-1 APB arbiter. Lets several APB requesters share one downstream APB port, for example several hart-side masters feeding apb_splitter.
- Picks one pending requester, captures its request into registers, and replays it downstream as a clean SETUP/ACCESS pair.
- Stalls all other requesters (pready low) until they are served.
- Forwards the granted requester's hart ID downstream with the transfer.

Parameters:
- N_MASTERS, 2, number of upstream requesters (range 2..8)
- W_ADDR, 16, APB address width
- W_DATA, 32, APB data width and hart-ID width

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- apbs_paddr  input  N_MASTERS*W_ADDR  per-requester address, packed, requester i at [i*W_ADDR +: W_ADDR]
- apbs_psel  input  N_MASTERS  per-requester select
- apbs_penable  input  N_MASTERS  per-requester enable
- apbs_pwrite  input  N_MASTERS  per-requester write flag
- apbs_pwdata  input  N_MASTERS*W_DATA  per-requester write data
- apbs_phartid  input  N_MASTERS*W_DATA  per-requester hart ID
- apbs_pready  output  N_MASTERS  per-requester ready
- apbs_prdata  output  N_MASTERS*W_DATA  per-requester read data
- apbs_pslverr  output  N_MASTERS  per-requester error
- apbm_paddr  output  W_ADDR  downstream address
- apbm_psel  output  1  downstream select
- apbm_penable  output  1  downstream enable
- apbm_pwrite  output  1  downstream write flag
- apbm_pwdata  output  W_DATA  downstream write data
- apbm_phartid  output  W_DATA  downstream hart ID
- apbm_pready  input  1  downstream ready
- apbm_prdata  input  W_DATA  downstream read data
- apbm_pslverr  input  1  downstream error

Behaviour:
- Single clock and single reset. Reset is rst_n: asynchronous assert, active-low.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - apbm_psel=0, apbm_penable=0, apbm_pwrite=0.
  - apbm_paddr, apbm_pwdata and apbm_phartid all 0.
  - apbs_pready=0, apbs_pslverr=0, apbs_prdata=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - A requester i is pending when apbs_psel[i]=1.
  - If any requester is pending, pick a winner with round-robin: search from rr_ptr upward, wrapping at N_MASTERS-1 back to 0.
  - Register grant, plus the winner's paddr, pwrite, pwdata and phartid. Go to SETUP.
  - If nothing is pending, stay in IDLE.
- SETUP: apbm_psel=1, apbm_penable=0. Unconditionally go to ACCESS.
- ACCESS:
  - apbm_psel=1, apbm_penable=1.
  - Hold ACCESS while apbm_pready=0.
  - When apbm_pready=1:
    - apbs_pready[grant]=1 in that same cycle (combinational).
    - apbs_prdata[grant]=apbm_prdata and apbs_pslverr[grant]=apbm_pslverr in that cycle.
    - rr_ptr <= (grant==N_MASTERS-1) ? 0 : grant+1. Go to IDLE.
- Downstream address, control, write data and hart ID come only from the capture registers. They stay stable from SETUP through ACCESS.
- Non-granted requesters, and every requester outside the completion cycle: pready=0, prdata=0, pslverr=0.
- Latency:
  - psel to pready is 3 cycles minimum (IDLE arbitrate, SETUP, ACCESS with pready=1).
  - Each downstream wait state adds 1 cycle.
- Back-to-back transfers: IDLE is re-entered for 1 cycle between them, so downstream psel deasserts for 1 cycle.
- Simultaneous requests: only one grant per arbitration. The losers stay pending and are served in rotation order.
- Granted requester drops psel mid-transfer (protocol violation):
  - The downstream transfer still completes.
  - The completion pulse is still driven on apbs_pready[grant]; it is not masked.
  - The FSM must never hang.
- New psel assertions during SETUP/ACCESS are ignored until the next IDLE.
- Reset asserted mid-transfer: all outputs return to reset values immediately; the in-flight transfer is abandoned.

Optional Feature:
- Macro: APB_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index pending requester always wins; rr_ptr is not implemented.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- Single write:
  - Stimulus: requester 0 writes addr 0x2004, data 0xDEADBEEF, phartid 0. Downstream pready=1 in the first ACCESS cycle.
  - Response: downstream SETUP then ACCESS carrying exactly those values; apbs_pready[0] pulses 1 cycle, 3 cycles after psel.
- Read with wait states:
  - Stimulus: requester 1 reads addr 0x4000; downstream holds pready=0 for 2 ACCESS cycles, then returns prdata 0x12345678.
  - Response: apbs_prdata[1]=0x12345678 with pready at cycle 5; apbs_pready[0]=0 throughout.
- Contention:
  - Stimulus: both requesters assert psel in the same cycle, with rr_ptr=0.
  - Response: requester 0 is served first, then requester 1; downstream phartid follows the grant (0, then 1).
  - Repeat the experiment: requester 1 now wins first.
- Error response:
  - Stimulus: downstream returns pslverr=1.
  - Response: apbs_pslverr[grant]=1 only in the completion cycle; the other requesters see 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during ACCESS.
  - Response: apbm_psel, apbm_penable and all apbs_pready go to 0 within the same cycle, with no clock edge needed.
  - After release, a new request completes normally.
- Fixed-priority build:
  - Stimulus: build with APB_ARBITER_FIXED_PRIO_EN defined; requester 0 issues continuous back-to-back requests while requester 1 is pending.
  - Response: requester 1 is never granted.
